// File: rtl/gcd_pkg.sv
// Constants shared by the gcd datapath and the blocks that consume its results.
package gcd_pkg;
   localparam int GCD_WIDTH = 32;
endpackage

// File: rtl/gcd_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module gcd_fifo_mem #(
   parameter int width_p = 32,
   parameter int els_p   = 4,
   localparam int PTR_W  = $clog2(els_p)
) (
   input  logic               clk_i,
   input  logic               w_v_i,
   input  logic [PTR_W-1:0]   w_addr_i,
   input  logic [width_p-1:0] w_data_i,
   input  logic [PTR_W-1:0]   r_addr_i,
   output logic [width_p-1:0] r_data_o
);
   logic [width_p-1:0] mem_q [els_p];

   always_ff @(posedge clk_i) begin
      if (w_v_i) mem_q[w_addr_i] <= w_data_i;
   end

   assign r_data_o = mem_q[r_addr_i];
endmodule

// File: rtl/gcd_result_fifo.sv
// Result FIFO between the gcd stage and its consumer; valid/yumi on both sides.
module gcd_result_fifo
   import gcd_pkg::*;
#(
   parameter int width_p = GCD_WIDTH,
   parameter int els_p   = 4,
   localparam int PTR_W  = $clog2(els_p),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               gcd_v_i,
   input  logic [width_p-1:0] gcd_data_i,
   output logic               gcd_yumi_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i,
   output logic [CNT_W-1:0]   count_o,
   output logic [15:0]        total_o
);
   logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [15:0]      total_q, total_d;
   logic             full, enq, deq;

   // Full is judged on registered count only, so a same-cycle dequeue never frees a slot.
   assign full = (count_q == CNT_W'(els_p));
   assign enq  = gcd_v_i & ~full & ~reset_i;
   assign v_o  = (count_q != '0) & ~reset_i;
   assign deq  = yumi_i & v_o;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      total_d = total_q;
      if (enq) begin
         wptr_d  = wptr_q + PTR_W'(1);
         total_d = total_q + 16'd1;
      end
      if (deq) rptr_d = rptr_q + PTR_W'(1);
      if (enq && !deq)      count_d = count_q + CNT_W'(1);
      else if (deq && !enq) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
         total_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         total_q <= total_d;
      end
   end

   gcd_fifo_mem #(.width_p(width_p), .els_p(els_p)) u_mem (
      .clk_i    (clk_i),
      .w_v_i    (enq),
      .w_addr_i (wptr_q),
      .w_data_i (gcd_data_i),
      .r_addr_i (rptr_q),
      .r_data_o (data_o)
   );

   assign gcd_yumi_o = enq;
   assign count_o    = count_q;
   assign total_o    = total_q;

   // A consumer taking from an empty FIFO is a protocol slip; it is ignored but reported.
   a_no_yumi_when_empty: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
      else $warning("gcd_result_fifo: yumi_i while empty, ignored");
endmodule

// File: tb/tb_gcd_result_fifo.sv
// Scoreboard bench: a queue model of the FIFO is checked every cycle by a monitor.
module tb_gcd_result_fifo;
   localparam int W = 32;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          gcd_v, gcd_yumi, v_o, yumi;
   logic [W-1:0]  gcd_data, data_o;
   logic [2:0]    count;
   logic [15:0]   total;

   int n_chk  = 0;
   int n_pass = 0;
   int unsigned q[$];
   int unsigned exp_total = 0;

   always #5 clk = ~clk;

   gcd_result_fifo #(.width_p(W), .els_p(D)) dut (
      .clk_i(clk), .reset_i(rst), .gcd_v_i(gcd_v), .gcd_data_i(gcd_data),
      .gcd_yumi_o(gcd_yumi), .v_o(v_o), .data_o(data_o), .yumi_i(yumi),
      .count_o(count), .total_o(total)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Monitor: on the falling edge, compare against the model and apply the coming edge to it.
   always @(negedge clk) begin
      bit ey;
      if (!rst) begin
         ey = gcd_v && (q.size() < D);
         chk("gcd_yumi_o", gcd_yumi, ey);
         chk("v_o", v_o, q.size() != 0);
         chk("count_o", count, q.size());
         chk("total_o", total, exp_total % 65536);
         if (yumi && q.size() != 0) begin
            chk("data_o", data_o, q[0]);
            void'(q.pop_front());
         end
         if (ey) begin
            q.push_back(gcd_data);
            exp_total++;
         end
      end
   end

   task automatic cyc(input bit v, input int unsigned d, input bit y);
      @(posedge clk); #1;
      gcd_v = v; gcd_data = d; yumi = y;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst v_o", v_o, 0);
      chk("rst count_o", count, 0);
      chk("rst total_o", total, 0);
      chk("rst gcd_yumi_o", gcd_yumi, 0);
      q.delete();
      exp_total = 0;
      #1 rst = 1'b0;
   endtask

   initial begin
      int unsigned snap;
      rst = 1'b1; gcd_v = 1'b1; gcd_data = 32'd99; yumi = 1'b0;
      #3;
      chk("init gcd_yumi_o", gcd_yumi, 0);
      chk("init v_o", v_o, 0);
      chk("init count_o", count, 0);
      chk("init total_o", total, 0);
      @(posedge clk); #1;
      rst = 1'b0; gcd_v = 1'b0;

      // Single result, one-cycle latency
      cyc(1, 6, 0);
      cyc(0, 0, 0);
      chk("s1 v_o", v_o, 1);
      chk("s1 data_o", data_o, 6);
      chk("s1 count_o", count, 1);
      chk("s1 total_o", total, 1);
      cyc(0, 0, 1);
      cyc(0, 0, 0);

      // Fill to full, enqueue refused even with a same-cycle dequeue
      for (int i = 1; i <= 4; i++) cyc(1, i, 0);
      cyc(1, 5, 0);
      chk("full count_o", count, 4);
      chk("full gcd_yumi_o", gcd_yumi, 0);
      yumi = 1'b1;
      #1 chk("full+deq gcd_yumi_o", gcd_yumi, 0);
      @(posedge clk); #1;
      chk("after deq count_o", count, 3);
      chk("after deq gcd_yumi_o", gcd_yumi, 1);
      gcd_v = 1'b0;
      for (int i = 0; i < 3; i++) cyc(0, 0, 1);
      cyc(0, 0, 0);
      chk("drained count_o", count, 0);

      // Streaming 10..19, pointers wrap twice
      for (int i = 0; i < 10; i++) cyc(1, 10 + i, i > 0);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      chk("stream count_o", count, 0);

      // Dequeue while empty: ignored
      snap = total;
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      chk("empty-yumi count_o", count, 0);
      chk("empty-yumi total_o", total, snap);

      // Mid-operation reset discards stored results; zero is ordinary data
      cyc(1, 32'hDEAD, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      chk("pre-reset count_o", count, 2);
      gcd_v = 1'b1; gcd_data = 77;
      pulse_reset();
      cyc(0, 0, 0);
      chk("post-reset count_o", count, 1);
      chk("post-reset data_o", data_o, 77);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      chk("post-reset drained v_o", v_o, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 1), $urandom, (q.size() != 0) && ($urandom_range(0, 2) != 0));
      gcd_v = 1'b0;
      for (int i = 0; i < D + 1; i++) cyc(0, 0, q.size() != 0);
      cyc(0, 0, 0);

      // total_o wraps after 65536 enqueues
      pulse_reset();
      gcd_v = 1'b0; yumi = 1'b0;
      for (int i = 0; i < 65537; i++) cyc(1, $urandom, i > 0);
      cyc(0, 0, 1);
      cyc(0, 0, 0);
      chk("wrap total_o", total, 1);
      chk("wrap count_o", count, 0);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/gcd_result_fifo.md
GCD_RESULT_FIFO -- requirements
Module: gcd_result_fifo

Interface
REQ-001 SHALL have parameter width_p, default 32, result word width matching the gcd data path.
REQ-002 SHALL have parameter els_p, default 4, FIFO depth; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port gcd_v_i  input  1  gcd result valid, driven by gcd v_o.
REQ-006 SHALL have port gcd_data_i  input  width_p  gcd result, driven by gcd data_o.
REQ-007 SHALL have port gcd_yumi_o  output  1  result accepted this cycle, drives gcd yumi_i.
REQ-008 SHALL have port v_o  output  1  head entry valid to consumer.
REQ-009 SHALL have port data_o  output  width_p  head entry.
REQ-010 SHALL have port yumi_i  input  1  consumer takes head this cycle.
REQ-011 SHALL have port count_o  output  $clog2(els_p)+1  current occupancy.
REQ-012 SHALL have port total_o  output  16  results accepted since reset, modulo 2^16.

Function
REQ-013 SHALL assert gcd_yumi_o = gcd_v_i & ~full, combinationally; full means count == els_p.
REQ-014 SHALL NOT let gcd_yumi_o depend on yumi_i: when full, enqueue is refused even if a dequeue occurs in the same cycle.
REQ-015 SHALL write gcd_data_i at the write pointer on a clock edge where gcd_yumi_o is 1, then advance the write pointer modulo els_p.
REQ-016 SHALL drive v_o = (count != 0) and data_o = entry at the read pointer; data_o is don't-care while v_o is 0.
REQ-017 SHALL advance the read pointer modulo els_p on an edge where yumi_i & v_o is 1.
REQ-018 SHALL ignore yumi_i while v_o is 0, with no state change, and SHALL flag that case with a simulation-only assertion.
REQ-019 SHALL keep count unchanged on a simultaneous enqueue and dequeue, increment it on enqueue only, and decrement it on dequeue only.
REQ-020 SHALL give one-cycle latency: a result enqueued at edge N is visible on data_o, with v_o high, after edge N when the FIFO was empty; there is no bypass path.
REQ-021 SHALL increment total_o on every enqueue and wrap from 0xFFFF to 0x0000.
REQ-022 SHALL treat a zero result (gcd of 0,0) as ordinary data.
REQ-023 SHALL pass data unchanged in order; there is no reordering or width conversion.

Reset
REQ-024 SHALL clear read pointer, write pointer, count and total_o to 0 immediately when reset_i is asserted, independent of clk_i.
REQ-025 SHALL hold gcd_yumi_o at 0, v_o at 0 and count_o at 0 while reset_i is high.
REQ-026 SHALL discard any stored results on mid-operation reset; storage contents are not reset and are never visible afterwards.
REQ-027 SHALL act on the first clock edge after reset_i deasserts.

Structure
REQ-028 SHALL take the gcd width constant (32) from the shared package gcd_pkg, which this block and the gcd stage both import.
REQ-029 SHALL place storage in one sub-module gcd_fifo_mem: els_p x width_p, 1 synchronous write port, 1 asynchronous read port, no reset.
REQ-030 SHALL keep pointers, count and total in the top module, with pointer width $clog2(els_p).

Verification
REQ-031 SHALL cover this scenario: gcd_v_i=1 with data 6, yumi_i=0 -> after one edge v_o=1, data_o=6, count_o=1, total_o=1.
REQ-032 SHALL cover this scenario: enqueue 1,2,3,4 with yumi_i=0 and gcd_v_i still high -> count_o=4 and gcd_yumi_o=0; then yumi_i=1 with gcd_v_i=1 -> no enqueue that cycle, count_o=3, then gcd_yumi_o=1.
REQ-033 SHALL cover this scenario: continuous gcd_v_i and yumi_i for 10 results 10..19 -> outputs 10..19 in order and pointers wrap twice.
REQ-034 SHALL cover this scenario: count_o=2, reset_i pulsed between edges -> v_o=0 and count_o=0 immediately, and prior data never reappears.
REQ-035 SHALL cover this scenario: yumi_i=1 while empty -> no state change and the assertion fires.
REQ-036 SHALL cover this scenario: 65537 enqueues -> total_o=1.
